// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops on two WIDTH-bit operands with zero/parity flags,
// carried through STAGES registers under valid/ready flow control with bubble collapse.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  op,
    input  logic [WIDTH-1:0]            in1,
    input  logic [WIDTH-1:0]            in2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out,
    output logic                        zero,
    output logic                        parity,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic calc_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  data_r [STAGES];
    logic [STAGES-1:0] zero_r;
    logic [STAGES-1:0] par_r;
    logic [OCC_W-1:0]  occ_r;

    logic [STAGES-1:0] adv_s;
    logic [WIDTH-1:0]  res_s;
    logic              accept_s;
    logic              exit_s;

    // Operation decode on the incoming operands
    always_comb begin
        res_s = {WIDTH{1'b0}};
        case (op)
            OP_AND:  res_s = in1 & in2;
            OP_OR:   res_s = in1 | in2;
            OP_XOR:  res_s = in1 ^ in2;
            OP_NOR:  res_s = ~(in1 | in2);
            OP_XNOR: res_s = ~(in1 ^ in2);
            OP_NAND: res_s = ~(in1 & in2);
            OP_ANDN: res_s = in1 & ~in2;
            OP_PASS: res_s = in1;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Advance chain: a stage moves when it is empty or its successor moves
    always_comb begin
        adv_s = {STAGES{1'b0}};
        adv_s[STAGES-1] = ~valid_r[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv_s[i] = ~valid_r[i] | adv_s[i+1];
        end
    end

    assign in_ready = adv_s[0];
    assign accept_s = in_valid & adv_s[0];
    assign exit_s   = valid_r[STAGES-1] & out_ready;

    // Pipeline stage registers; empty stages always load so bubbles collapse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
            zero_r  <= {STAGES{1'b0}};
            par_r   <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= in_valid;
                data_r[0]  <= res_s;
                zero_r[0]  <= calc_zero(res_s);
                par_r[0]   <= calc_parity(res_s);
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv_s[i]) begin
                    valid_r[i] <= valid_r[i-1];
                    data_r[i]  <= data_r[i-1];
                    zero_r[i]  <= zero_r[i-1];
                    par_r[i]   <= par_r[i-1];
                end
            end
        end
    end

    // Occupancy counter tracks accepts against exits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            case ({accept_s, exit_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign out       = data_r[STAGES-1];
    assign zero      = zero_r[STAGES-1];
    assign parity    = par_r[STAGES-1];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: STAGES=2 instance for ops/flags/backpressure/reset,
// STAGES=4 instance for bubble collapse.
module tb_logic_unit_pipe;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
        logic        pf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_parity;
    logic [2:0]  a_op;
    logic [31:0] a_in1, a_in2, a_out;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_parity;
    logic [2:0]  b_op;
    logic [31:0] b_in1, b_in2, b_out;
    logic [2:0]  b_occ;

    logic_unit_pipe #(.WIDTH(32), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .in1(a_in1), .in2(a_in2), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out(a_out), .zero(a_zero), .parity(a_parity),
        .occupancy(a_occ)
    );

    logic_unit_pipe #(.WIDTH(32), .STAGES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out(b_out), .zero(b_zero), .parity(b_parity),
        .occupancy(b_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [2:0] o, input logic [31:0] d1,
                           input logic [31:0] d2, input logic ordy);
        a_in_valid = v; a_op = o; a_in1 = d1; a_in2 = d2; a_out_ready = ordy;
        #1;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] d1, input logic ordy);
        b_in_valid = v; b_op = 3'b111; b_in1 = d1; b_in2 = 32'h0; b_out_ready = ordy;
        #1;
    endtask

    vec_t vecs [10];
    int   sent, rcvd;
    logic stale;

    initial begin
        vecs[0] = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b1};
        vecs[1] = '{3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b1};
        vecs[3] = '{3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00FF_1234, 1'b0, 1'b1};
        vecs[5] = '{3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB, 1'b0, 1'b1};
        vecs[6] = '{3'b110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000, 1'b0, 1'b0};
        vecs[7] = '{3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234, 1'b0, 1'b1};
        vecs[8] = '{3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9] = '{3'b111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1'b1};

        rst_n = 1'b0;
        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        b_drive(1'b0, 32'h0, 1'b1);
        #2;
        check("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
        check("rst_out", a_out, 32'h0);
        check("rst_flags", {30'h0, a_zero, a_parity}, 32'h0);
        check("rst_occ", {30'h0, a_occ}, 32'h0);
        check("rst_occ_b", {29'h0, b_occ}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'h0, a_in_ready}, 32'h1);
        tick();

        // all ops and flag vectors, one per cycle, result two cycles later
        for (int k = 0; k < 12; k++) begin
            if (k < 10) a_drive(1'b1, vecs[k].op, vecs[k].a, vecs[k].b, 1'b1);
            else        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
            if (k < 10) check($sformatf("op%0d_in_ready", k), {31'h0, a_in_ready}, 32'h1);
            if (k >= 2) begin
                check($sformatf("vec%0d_valid", k - 2), {31'h0, a_out_valid}, 32'h1);
                check($sformatf("vec%0d_out", k - 2), a_out, vecs[k-2].res);
                check($sformatf("vec%0d_zero", k - 2), {31'h0, a_zero}, {31'h0, vecs[k-2].zf});
                check($sformatf("vec%0d_par", k - 2), {31'h0, a_parity}, {31'h0, vecs[k-2].pf});
            end
            tick();
        end
        check("ops_drained", {31'h0, a_out_valid}, 32'h0);

        // backpressure: stream 5 beats with out_ready low, then drain
        sent = 0; rcvd = 0;
        for (int c = 0; c < 5; c++) begin
            a_drive(1'b1, 3'b111, 32'(sent + 1), 32'h0, 1'b0);
            if (a_in_ready) sent++;
            tick();
        end
        check("bp_accepted", 32'(sent), 32'd2);
        check("bp_in_ready", {31'h0, a_in_ready}, 32'h0);
        check("bp_occ", {30'h0, a_occ}, 32'd2);
        check("bp_out_hold", a_out, 32'd1);
        check("bp_out_valid", {31'h0, a_out_valid}, 32'h1);
        for (int c = 0; c < 40 && rcvd < 5; c++) begin
            a_drive(sent < 5, 3'b111, 32'(sent + 1), 32'h0, 1'b1);
            if (a_out_valid) begin
                check($sformatf("bp_drain%0d", rcvd), a_out, 32'(rcvd + 1));
                rcvd++;
            end
            if (sent < 5 && a_in_ready) sent++;
            tick();
        end
        check("bp_rcvd", 32'(rcvd), 32'd5);
        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        tick();
        check("bp_no_dup", {31'h0, a_out_valid}, 32'h0);

        // simultaneous accept/exit on a full pipeline
        for (int c = 0; c < 2; c++) begin
            a_drive(1'b1, 3'b111, 32'(16 + c), 32'h0, 1'b0);
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            a_drive(1'b1, 3'b111, 32'(32 + c), 32'h0, 1'b1);
            check($sformatf("sim_in_ready%0d", c), {31'h0, a_in_ready}, 32'h1);
            check($sformatf("sim_occ%0d", c), {30'h0, a_occ}, 32'd2);
            tick();
        end
        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        tick(); tick(); tick();
        check("sim_drained_occ", {30'h0, a_occ}, 32'd0);

        // reset with two beats in flight
        for (int c = 0; c < 2; c++) begin
            a_drive(1'b1, 3'b111, 32'hDEAD_0000 + 32'(c), 32'h0, 1'b0);
            tick();
        end
        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'h0, a_out_valid}, 32'h0);
        check("mid_rst_occ", {30'h0, a_occ}, 32'h0);
        check("mid_rst_out", a_out, 32'h0);
        tick();
        rst_n = 1'b1;
        a_drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        check("post_rst_in_ready", {31'h0, a_in_ready}, 32'h1);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_out_valid) stale = 1'b1;
            tick();
        end
        check("post_rst_no_stale", {31'h0, stale}, 32'h0);

        // bubble collapse on the 4-stage instance
        for (int c = 0; c < 6; c++) begin
            b_drive(c == 0 || c == 3, (c == 0) ? 32'h11 : 32'h22, 1'b0);
            tick();
        end
        b_drive(1'b0, 32'h0, 1'b0);
        check("bub_occ2", {29'h0, b_occ}, 32'd2);
        check("bub_out_head", b_out, 32'h11);
        check("bub_out_valid", {31'h0, b_out_valid}, 32'h1);
        for (int c = 0; c < 2; c++) begin
            b_drive(1'b1, 32'h33 + 32'(c * 17), 1'b0);
            check($sformatf("bub_fill_ready%0d", c), {31'h0, b_in_ready}, 32'h1);
            tick();
        end
        b_drive(1'b1, 32'h55, 1'b0);
        check("bub_full_occ", {29'h0, b_occ}, 32'd4);
        check("bub_full_ready", {31'h0, b_in_ready}, 32'h0);
        rcvd = 0;
        for (int c = 0; c < 20 && rcvd < 4; c++) begin
            b_drive(1'b0, 32'h0, 1'b1);
            if (b_out_valid) begin
                check($sformatf("bub_drain%0d", rcvd), b_out, 32'h11 * 32'(rcvd + 1));
                rcvd++;
            end
            tick();
        end
        check("bub_rcvd", 32'(rcvd), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit bitwise XOR block used by the Proc32Bit ALU.
- Performs one of eight bitwise operations on two WIDTH-bit operands and adds zero and parity flags.
- Carries each result through STAGES registered pipeline stages, with valid/ready flow control and bubble collapse.
- Sits between the operand-fetch stage and the ALU result mux, so upstream decode stalls cleanly.

Parameters:
- WIDTH, 32, operand and result width in bits (≥1).
- STAGES, 2, number of pipeline register stages (1..4); sets the no-stall latency.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat is present.
- in_ready  output  1  block accepts the beat this cycle.
- op  input  3  operation select, sampled with the operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  a result is present.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  result data.
- zero  output  1  high when out is all zeros.
- parity  output  1  XOR-reduction of out.
- occupancy  output  $clog2(STAGES+1)  number of valid stages, 0..STAGES.

Behaviour:
- **Op encoding:**
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 XNOR, 101 NAND, 110 ANDN (in1 & ~in2), 111 PASS (out = in1).
- **Operation timing:** evaluated combinationally on entry. Result, zero and parity are captured into stage 0 on acceptance, then shifted unchanged through later stages.
- **Acceptance:** a beat is accepted when in_valid && in_ready at the clock edge. op, in1 and in2 are used only in that cycle.
- **Stage advance rule:**
  - Last stage: advances when it is empty or out_ready = 1.
  - Stage i < STAGES-1: advances when it is empty or stage i+1 advances.
  - in_ready = stage 0 advances. It is combinational from out_ready and the stage valids, with no register in that path.
- **Latency:** with out_ready held high, a beat accepted at edge N is on out/out_valid after edge N+STAGES-1, i.e. STAGES cycles after in_valid is first presented. Throughput is 1 beat/cycle.
- **Bubble collapse:** an empty stage always loads from its predecessor, so gaps close while the output is stalled. Occupancy can reach STAGES.
- **Stall:** while out_valid && !out_ready, out, zero, parity and out_valid hold stable. No beat is dropped or duplicated. When the pipeline is full and stalled, in_ready = 0.
- **Simultaneous events:** when full and out_ready = 1, one beat leaves and one new beat is accepted in the same cycle, so occupancy is unchanged.
- **Occupancy:** count of set stage-valid bits.
  - +1 on accept without exit, -1 on exit without accept, unchanged when both or neither occur.
  - Never exceeds STAGES and never goes below 0.
- **Reset:**
  - rst_n low immediately clears all stage valids, data and flags.
  - Outputs during reset: out_valid = 0, out = 0, zero = 0, parity = 0, occupancy = 0.
  - in_ready is 1 once reset releases (pipeline empty).
  - Asserting reset mid-stream discards all in-flight beats; nothing is emitted after release until new beats are accepted.
- **Idle outputs:** out, zero and parity are meaningful only when out_valid = 1. When a stage is empty, its data registers are not required to clear.
- **Width rules:** zero and parity always cover all WIDTH bits. There is no carry or overflow.

Test Plan:
- **Reset/idle:** assert rst_n = 0 mid-cycle with 2 beats in flight, then release → out_valid = 0, occupancy = 0, in_ready = 1, and no stale result appears within 10 cycles.
- **All ops, WIDTH = 32, STAGES = 2, out_ready = 1:** in1 = 0xF0F0_1234, in2 = 0x0FF0_FFFF, op 0..7 on consecutive cycles → out = 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, 0x00FF_1234, 0xFF0F_EDCB, 0xF000_0000, 0xF0F0_1234, each 2 cycles after its beat, one per cycle.
- **Flags:** XOR of 0xA5A5_A5A5 with itself → out = 0, zero = 1, parity = 0. PASS of 0x0000_0007 → zero = 0, parity = 1.
- **Backpressure:** hold out_ready = 0 and stream 5 beats → exactly STAGES beats are accepted, in_ready drops, occupancy = 2 and out holds the first result. Raise out_ready → all results emerge in order with no loss or duplication.
- **Bubble collapse, STAGES = 4:** send beats at cycles 0 and 3 with out_ready = 0 → occupancy reaches 2, and both beats sit in the last two stages before any new beat is sent.
- **Simultaneous accept/exit:** full pipeline, out_ready = 1, in_valid = 1 continuously for 8 cycles → occupancy stays at STAGES and in_ready stays 1 throughout.
